axi_ar_req_queue: RTL and testbench
===================================

Name: axi_ar_req_queue

Overview:
- Multi-channel AXI read-address request queue, single clock domain; next generation of the instruction-side AR request path.
- Accepts read requests from NUM_CH requesters (e.g. imem, dmem, prefetch) through per-channel FIFOs of depth DEPTH.
- Round-robin arbitrates the FIFO heads onto one AXI AR channel, tagging ARID with the channel index.
- Caps outstanding bursts at MAX_OUTST.

Parameters:
- NUM_CH, 2, number of requester channels (1..8).
- ADDR_W, 64, address width.
- DEPTH, 4, entries per channel FIFO; power of two, >= 2.
- MAX_OUTST, 8, maximum issued-but-uncompleted bursts (1..255).
- ID_W, 3, ARID width; must satisfy 2**ID_W >= NUM_CH.

Ports:
- axi_clk  in  1  clock.
- axi_resetn  in  1  asynchronous active-low reset.
- req_araddr_i  in  NUM_CH*ADDR_W  per-channel address; channel c at slice [c*ADDR_W +: ADDR_W].
- req_arlen_i  in  NUM_CH*8  per-channel burst length.
- req_arsize_i  in  NUM_CH*3  per-channel beat size.
- req_arburst_i  in  NUM_CH*2  per-channel burst type.
- req_valid_i  in  NUM_CH  per-channel request valid.
- req_ready_o  out  NUM_CH  per-channel FIFO not full.
- flush_i  in  1  synchronous clear of all channel FIFOs.
- resp_done_i  in  1  one burst completed (rvalid & rready & rlast), one pulse per burst.
- arready_i  in  1  AXI slave ready.
- araddr_o  out  ADDR_W  AXI ARADDR.
- arlen_o  out  8  AXI ARLEN.
- arsize_o  out  3  AXI ARSIZE.
- arburst_o  out  2  AXI ARBURST.
- arid_o  out  ID_W  AXI ARID, equal to the granted channel index.
- arvalid_o  out  1  AXI ARVALID.
- outst_cnt_o  out  8  current outstanding-burst count.

Behaviour:
Reset
- axi_resetn low asynchronously clears:
  - all FIFO pointers (all channels empty);
  - the output register (araddr_o/arlen_o/arsize_o/arburst_o/arid_o = 0, arvalid_o = 0);
  - the round-robin pointer (to 0) and outst_cnt_o (to 0).
- After reset, req_ready_o = all ones.
- Reset asserted mid-burst drops all state; no completion is expected afterwards.

Enqueue
- Channel c writes its FIFO at the clock edge when req_valid_i[c] & req_ready_o[c].
- req_ready_o[c] = ~full[c], registered-pointer based. No same-cycle write-through when full, even if that channel is popped.
- Pointers are log2(DEPTH)+1 bits with a wrap bit:
  - full = addresses equal and wrap bits differ;
  - empty = pointers equal.

Issue
- Output register "load" condition: (~arvalid_o | arready_i) & any FIFO non-empty & outst_cnt_o < MAX_OUTST & ~flush_i.
- Arbiter grants the first non-empty channel at or after rr_ptr (modulo NUM_CH).
- On load:
  - the head of the granted channel is copied to the output register and popped;
  - arid_o = grant; arvalid_o = 1;
  - rr_ptr = (grant+1) mod NUM_CH.
- If arvalid_o & arready_i and there is no load, arvalid_o clears.
- While arvalid_o & ~arready_i, every AR output holds stable (AXI rule).
- Latency: request accepted at edge N is on AR at edge N+1, i.e. earliest arvalid_o at cycle N+1 after write. Back-to-back issue is 1 request per cycle.

Outstanding count
- outst_cnt_o increments on load.
- It decrements on resp_done_i when nonzero.
- Load and resp_done_i in the same cycle leave it unchanged.
- resp_done_i with count 0 is ignored; simulation assertion fires.
- Load is blocked when count = MAX_OUTST, even if resp_done_i is high that cycle. This keeps timing off the response path.

Flush
- flush_i clears all FIFO pointers at the edge and suppresses load that cycle.
- A pending arvalid_o is not dropped; it completes normally.
- A write coinciding with flush_i is discarded.

Decomposition:
- Shared package axi_pkg holds:
  - typedef ar_req_t {addr, len, size, burst};
  - burst encodings BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10.
- One natural sub-module, req_fifo: a single-clock FIFO with async active-low reset, parametrised on DEPTH and ar_req_t, exposing push/pop/full/empty/head/flush.
- It is instantiated NUM_CH times in a generate loop; the arbiter and output register stay in the top.

Test Plan:
1. Reset release, ch0 pushes addr 0x1000 len 7 size 3 burst INCR, arready_i=1 -> arvalid_o high one cycle later with araddr_o=0x1000, arlen_o=7, arid_o=0, outst_cnt_o=1.
2. ch0 and ch1 each push 3 requests in the same cycles, arready_i=1 -> AR order on arid_o is 0,1,0,1,0,1 with no idle cycles between grants.
3. arready_i held 0 for 5 cycles with a request pending -> all AR outputs stable across all 5 cycles; FIFO fills, req_ready_o[0] drops after DEPTH=4 further accepts.
4. MAX_OUTST=2, 3 requests queued, no resp_done_i -> exactly 2 handshakes, then arvalid_o stays 0. One resp_done_i pulse -> third request issues the next cycle; outst_cnt_o sequence is 2,1,2.
5. flush_i pulsed with 3 entries queued and one AR pending under arready_i=0 -> the pending AR completes when arready_i rises; no further AR; req_ready_o = all ones the cycle after flush.
6. axi_resetn dropped mid-stream with arvalid_o=1 and outst_cnt_o=3 -> arvalid_o=0 and outst_cnt_o=0 immediately, without waiting for a clock edge; a resp_done_i pulse after reset leaves the count at 0.

Source files
------------

// File: rtl/axi_ar_req_queue_pkg.sv
// Shared AR request types for the multi-channel read-address queue.
// The address field is sized for the widest supported bus; narrower tops zero-extend.
package axi_pkg;

  localparam int AR_ADDR_MAX = 64;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic [AR_ADDR_MAX-1:0] addr;
    logic [7:0]             len;
    logic [2:0]             size;
    logic [1:0]             burst;
  } ar_req_t;

endpackage

// File: rtl/axi_ar_req_queue_req_fifo.sv
// Single-clock request FIFO with wrap-bit pointers and a synchronous flush.
// Flush has priority over push and pop.
module req_fifo
  import axi_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = ar_req_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_flush,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output logic o_full,
  output logic o_empty,
  output T     o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  T            r_mem [DEPTH];
  logic        w_push;
  logic        w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_push  = i_push & ~o_full & ~i_flush;
  assign w_pop   = i_pop & ~o_empty & ~i_flush;
  assign o_head  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/axi_ar_req_queue.sv
// Multi-channel AXI AR request queue: per-channel FIFOs, round-robin grant onto
// one AR channel (ARID = channel index), and an outstanding-burst cap.
module axi_ar_req_queue
  import axi_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 64,
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 8,
  parameter int ID_W      = 3
) (
  input  logic                     axi_clk,
  input  logic                     axi_resetn,
  input  logic [NUM_CH*ADDR_W-1:0] req_araddr_i,
  input  logic [NUM_CH*8-1:0]      req_arlen_i,
  input  logic [NUM_CH*3-1:0]      req_arsize_i,
  input  logic [NUM_CH*2-1:0]      req_arburst_i,
  input  logic [NUM_CH-1:0]        req_valid_i,
  output logic [NUM_CH-1:0]        req_ready_o,
  input  logic                     flush_i,
  input  logic                     resp_done_i,
  input  logic                     arready_i,
  output logic [ADDR_W-1:0]        araddr_o,
  output logic [7:0]               arlen_o,
  output logic [2:0]               arsize_o,
  output logic [1:0]               arburst_o,
  output logic [ID_W-1:0]          arid_o,
  output logic                     arvalid_o,
  output logic [7:0]               outst_cnt_o
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [7:0] OUTST_MAX = 8'(MAX_OUTST);

  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  ar_req_t           w_in   [NUM_CH];
  ar_req_t           w_head [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_in[c] = {AR_ADDR_MAX'(req_araddr_i[c*ADDR_W +: ADDR_W]),
                      req_arlen_i[c*8 +: 8], req_arsize_i[c*3 +: 3],
                      req_arburst_i[c*2 +: 2]};
    assign w_push[c] = req_valid_i[c] & ~w_full[c];

    req_fifo #(.DEPTH(DEPTH), .T(ar_req_t)) u_fifo (
      .clk     (axi_clk),
      .rst_n   (axi_resetn),
      .i_flush (flush_i),
      .i_push  (w_push[c]),
      .i_data  (w_in[c]),
      .i_pop   (w_pop[c]),
      .o_full  (w_full[c]),
      .o_empty (w_empty[c]),
      .o_head  (w_head[c])
    );
  end

  assign req_ready_o = ~w_full;

  logic [CH_W-1:0] r_rr_ptr;
  logic [CH_W-1:0] w_grant;
  logic [CH_W-1:0] w_idx;
  logic [CH_W-1:0] w_rr_next;
  logic            w_found;
  logic            w_load;
  logic            w_dec;
  ar_req_t         w_sel;

  // Scan channels starting at the round-robin pointer; first non-empty wins.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = CH_W'((int'(r_rr_ptr) + k) % NUM_CH);
      if (!w_found && !w_empty[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  assign w_rr_next = (w_grant == CH_W'(NUM_CH - 1)) ? '0 : w_grant + 1'b1;
  assign w_sel     = w_head[w_grant];
  assign w_load    = (~arvalid_o | arready_i) & w_found & (outst_cnt_o < OUTST_MAX) & ~flush_i;
  assign w_dec     = resp_done_i & (outst_cnt_o != 8'd0);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_pop
    assign w_pop[c] = w_load && (w_grant == CH_W'(c));
  end

  // AR output register: holds stable while arvalid_o is stalled by arready_i.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      araddr_o  <= '0;
      arlen_o   <= '0;
      arsize_o  <= '0;
      arburst_o <= '0;
      arid_o    <= '0;
      arvalid_o <= 1'b0;
      r_rr_ptr  <= '0;
    end else if (w_load) begin
      araddr_o  <= w_sel.addr[ADDR_W-1:0];
      arlen_o   <= w_sel.len;
      arsize_o  <= w_sel.size;
      arburst_o <= w_sel.burst;
      arid_o    <= ID_W'(w_grant);
      arvalid_o <= 1'b1;
      r_rr_ptr  <= w_rr_next;
    end else if (arready_i) begin
      arvalid_o <= 1'b0;
    end
  end

  // The cap compares against the registered count only, keeping resp_done_i off the load path.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      outst_cnt_o <= '0;
    end else if (w_load && !w_dec) begin
      outst_cnt_o <= outst_cnt_o + 8'd1;
    end else if (!w_load && w_dec) begin
      outst_cnt_o <= outst_cnt_o - 8'd1;
    end
  end

  a_no_spurious_done: assert property (@(posedge axi_clk) disable iff (!axi_resetn)
    resp_done_i |-> (outst_cnt_o != 8'd0))
    else $warning("resp_done_i received with no outstanding burst; ignored");

endmodule

// File: tb/tb_axi_ar_req_queue.sv
// Bench for axi_ar_req_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_axi_ar_req_queue;
  import axi_pkg::*;

  localparam int NC   = 2;
  localparam int AW   = 64;
  localparam int DEP  = 4;
  localparam int MAXO = 8;
  localparam int IDW  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC*AW-1:0]  araddr;
  logic [NC*8-1:0]   arlen;
  logic [NC*3-1:0]   arsize;
  logic [NC*2-1:0]   arburst;
  logic [NC-1:0]     valid;
  logic              flush, done, done2, arready;

  logic [NC-1:0]  rdy, rdy2;
  logic [AW-1:0]  a_addr, a2_addr;
  logic [7:0]     a_len, a2_len, cnt, cnt2;
  logic [2:0]     a_size, a2_size;
  logic [1:0]     a_burst, a2_burst;
  logic [IDW-1:0] a_id, a2_id;
  logic           a_vld, a2_vld;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  axi_ar_req_queue #(.NUM_CH(NC), .ADDR_W(AW), .DEPTH(DEP), .MAX_OUTST(MAXO), .ID_W(IDW)) dut (
    .axi_clk(clk), .axi_resetn(rst_n), .req_araddr_i(araddr), .req_arlen_i(arlen),
    .req_arsize_i(arsize), .req_arburst_i(arburst), .req_valid_i(valid), .req_ready_o(rdy),
    .flush_i(flush), .resp_done_i(done), .arready_i(arready), .araddr_o(a_addr),
    .arlen_o(a_len), .arsize_o(a_size), .arburst_o(a_burst), .arid_o(a_id),
    .arvalid_o(a_vld), .outst_cnt_o(cnt));

  // Second instance with a tight outstanding cap; shares all inputs except resp_done_i.
  axi_ar_req_queue #(.NUM_CH(NC), .ADDR_W(AW), .DEPTH(DEP), .MAX_OUTST(2), .ID_W(IDW)) dut2 (
    .axi_clk(clk), .axi_resetn(rst_n), .req_araddr_i(araddr), .req_arlen_i(arlen),
    .req_arsize_i(arsize), .req_arburst_i(arburst), .req_valid_i(valid), .req_ready_o(rdy2),
    .flush_i(flush), .resp_done_i(done2), .arready_i(arready), .araddr_o(a2_addr),
    .arlen_o(a2_len), .arsize_o(a2_size), .arburst_o(a2_burst), .arid_o(a2_id),
    .arvalid_o(a2_vld), .outst_cnt_o(cnt2));

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
  } req_t;

  // Reference model: one queue per channel, the AR beat currently presented, a count.
  req_t mq [NC][$];
  req_t m_out;
  bit   m_vld;
  int   m_id, m_rr, m_cnt, m_g;
  bit   m_ld, m_dec;
  bit   m_rdy [NC];

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int c = 0; c < NC; c++) mq[c].delete();
      m_out = '0; m_vld = 0; m_id = 0; m_rr = 0; m_cnt = 0;
    end else begin
      for (int c = 0; c < NC; c++) m_rdy[c] = (mq[c].size() < DEP);
      m_g = -1;
      for (int k = 0; k < NC; k++)
        if (m_g < 0 && mq[(m_rr + k) % NC].size() > 0) m_g = (m_rr + k) % NC;
      m_ld  = (!m_vld || arready) && (m_g >= 0) && (m_cnt < MAXO) && !flush;
      m_dec = done && (m_cnt > 0);
      if (m_ld) begin
        m_out = mq[m_g].pop_front();
        m_id  = m_g;
        m_vld = 1;
        m_rr  = (m_g + 1) % NC;
      end else if (arready) begin
        m_vld = 0;
      end
      m_cnt = m_cnt + (m_ld ? 1 : 0) - (m_dec ? 1 : 0);
      if (flush) begin
        for (int c = 0; c < NC; c++) mq[c].delete();
      end else begin
        for (int c = 0; c < NC; c++)
          if (valid[c] && m_rdy[c])
            mq[c].push_back({araddr[c*AW +: AW], arlen[c*8 +: 8], arsize[c*3 +: 3], arburst[c*2 +: 2]});
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [NC-1:0] cmp_rdy;
  initial forever begin
    @(negedge clk);
    for (int c = 0; c < NC; c++) cmp_rdy[c] = (mq[c].size() < DEP);
    chk("model_ready",   rdy,     cmp_rdy);
    chk("model_arvalid", a_vld,   m_vld);
    chk("model_araddr",  a_addr,  m_out.addr);
    chk("model_arlen",   a_len,   m_out.len);
    chk("model_arsize",  a_size,  m_out.size);
    chk("model_arburst", a_burst, m_out.burst);
    chk("model_arid",    a_id,    IDW'(m_id));
    chk("model_outst",   cnt,     8'(m_cnt));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic v, input logic [AW-1:0] a,
                        input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    valid[c]          = v;
    araddr[c*AW +: AW] = a;
    arlen[c*8 +: 8]   = l;
    arsize[c*3 +: 3]  = s;
    arburst[c*2 +: 2] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    flush = 1'b0; done = 1'b0; done2 = 1'b0; arready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int hs;

  initial begin
    do_reset();
    chk("rst_ready",   rdy,   2'b11);
    chk("rst_arvalid", a_vld, 1'b0);
    chk("rst_outst",   cnt,   8'd0);
    chk("rst_araddr",  a_addr, 64'd0);

    // First request reaches AR one edge after it is accepted.
    arready = 1'b1;
    set_ch(0, 1'b1, 64'h1000, 8'd7, 3'd3, BURST_INCR);
    tick();
    valid = '0;
    tick();
    chk("t1_arvalid", a_vld,  1'b1);
    chk("t1_araddr",  a_addr, 64'h1000);
    chk("t1_arlen",   a_len,  8'd7);
    chk("t1_arsize",  a_size, 3'd3);
    chk("t1_arid",    a_id,   3'd0);
    chk("t1_outst",   cnt,    8'd1);

    // Alternating grants with no idle cycle.
    do_reset();
    arready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 3) begin
        set_ch(0, 1'b1, 64'h2000 + 64'(i * 16), 8'd1, 3'd2, BURST_INCR);
        set_ch(1, 1'b1, 64'h3000 + 64'(i * 16), 8'd3, 3'd2, BURST_WRAP);
      end else begin
        valid = '0;
      end
      tick();
      if (i >= 1 && i <= 6) begin
        chk("t2_arvalid", a_vld, 1'b1);
        chk("t2_arid",    a_id,  IDW'((i - 1) % 2));
      end
    end

    // Stall: AR stays stable while the channel-0 FIFO fills behind it.
    do_reset();
    arready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_ch(0, 1'b1, 64'h4000 + 64'(i * 4), 8'(i), 3'd2, BURST_INCR);
      tick();
      if (i >= 1 && i <= 5) begin
        chk("t3_arvalid", a_vld,   1'b1);
        chk("t3_araddr",  a_addr,  64'h4000);
        chk("t3_arlen",   a_len,   8'd0);
        chk("t3_arburst", a_burst, BURST_INCR);
      end
      if (i == 3) chk("t3_ready_before_full", rdy[0], 1'b1);
      if (i == 4) chk("t3_ready_full",        rdy[0], 1'b0);
    end
    valid = '0;
    arready = 1'b1;
    repeat (6) tick();

    // Outstanding cap of 2 on the second instance.
    do_reset();
    arready = 1'b1;
    hs = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 3) set_ch(0, 1'b1, 64'h5000 + 64'(i * 4), 8'd0, 3'd3, BURST_FIXED);
      else valid = '0;
      tick();
      if (a2_vld) hs++;
    end
    chk("t4_handshakes", 64'(hs), 64'd2);
    chk("t4_vld_blocked", a2_vld, 1'b0);
    chk("t4_cnt_full",    cnt2,   8'd2);
    done2 = 1'b1;
    tick();
    done2 = 1'b0;
    chk("t4_cnt_after_done", cnt2,   8'd1);
    chk("t4_vld_after_done", a2_vld, 1'b0);
    tick();
    chk("t4_third_vld",  a2_vld,  1'b1);
    chk("t4_third_addr", a2_addr, 64'h5008);
    chk("t4_cnt_refill", cnt2,    8'd2);

    // Flush with a stalled AR pending and entries queued.
    do_reset();
    arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_ch(0, 1'b1, 64'h6000 + 64'(i * 4), 8'd2, 3'd1, BURST_INCR);
      tick();
    end
    valid = '0;
    flush = 1'b1;
    set_ch(1, 1'b1, 64'h7000, 8'd9, 3'd1, BURST_INCR);
    tick();
    flush = 1'b0;
    valid = '0;
    chk("t5_ready_after_flush", rdy,    2'b11);
    chk("t5_pending_vld",       a_vld,  1'b1);
    chk("t5_pending_addr",      a_addr, 64'h6000);
    arready = 1'b1;
    tick();
    chk("t5_drained", a_vld, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_more_ar", a_vld, 1'b0);
    end

    // Asynchronous reset mid-stream.
    do_reset();
    arready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_ch(0, 1'b1, 64'h8000 + 64'(i * 4), 8'd4, 3'd3, BURST_INCR);
      tick();
    end
    valid = '0;
    tick();
    arready = 1'b0;
    chk("t6_pre_vld", a_vld, 1'b1);
    chk("t6_pre_cnt", cnt,   8'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_vld",   a_vld, 1'b0);
    chk("t6_async_cnt",   cnt,   8'd0);
    chk("t6_async_ready", rdy,   2'b11);
    tick();
    tick();
    rst_n = 1'b1;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk("t6_cnt_stays_zero", cnt, 8'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int c = 0; c < NC; c++)
        set_ch(c, ($urandom_range(0, 2) != 0), {$urandom, $urandom}, 8'($urandom_range(0, 255)),
               3'($urandom_range(0, 7)),
               ($urandom_range(0, 2) == 0) ? BURST_FIXED :
               ($urandom_range(0, 1) == 0) ? BURST_INCR : BURST_WRAP);
      arready = ($urandom_range(0, 3) != 0);
      done    = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
      flush   = ($urandom_range(0, 39) == 0);
      rst_n   = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1'b1;
    valid = '0;
    flush = 1'b0;
    done  = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
